// File: rtl/grf_writeback.sv
// 32 x 32-bit MIPS general register file with an optional write-through read path,
// a registered commit-trace record and a commit counter.
module grf_writeback #(
    parameter int BYPASS = 0,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    input  logic [4:0]       A3,
    input  logic [31:0]      WD,
    input  logic [31:0]      PC,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             wb_valid,
    output logic [31:0]      wb_pc,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0]      r_regs [32];
    logic             r_wb_valid;
    logic [31:0]      r_wb_pc;
    logic [4:0]       r_wb_addr;
    logic [31:0]      r_wb_data;
    logic [CNT_W-1:0] r_wr_count;
    logic             w_commit;
    logic [31:0]      w_rd1;
    logic [31:0]      w_rd2;

    // $0 targets (including a squashed bnezalc) never commit, and nothing commits under reset.
    assign w_commit = WE && (A3 != 5'd0) && !reset;

    // NOTE: the array is cleared by the async reset so reads return 0 while reset is held;
    // this also keeps it as flops rather than a RAM macro, which could not be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
            r_regs[A3] <= WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_pc    <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wr_count <= '0;
        end else begin
            r_wb_valid <= w_commit;
            if (w_commit) begin
                r_wb_pc    <= PC;
                r_wb_addr  <= A3;
                r_wb_data  <= WD;
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    // NOTE: a default is assigned first so every path drives the output and no latch is inferred.
    always_comb begin
        w_rd1 = r_regs[A1];
        if (A1 == 5'd0) begin
            w_rd1 = '0;
        end else if ((BYPASS != 0) && w_commit && (A1 == A3)) begin
            w_rd1 = WD;
        end
    end

    always_comb begin
        w_rd2 = r_regs[A2];
        if (A2 == 5'd0) begin
            w_rd2 = '0;
        end else if ((BYPASS != 0) && w_commit && (A2 == A3)) begin
            w_rd2 = WD;
        end
    end

    assign RD1      = w_rd1;
    assign RD2      = w_rd2;
    assign wb_valid = r_wb_valid;
    assign wb_pc    = r_wb_pc;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_grf_writeback.sv
// Bench for grf_writeback: a stored-read instance, a write-through instance and a 4-bit-counter
// instance share stimulus; commit records are scoreboarded against the trace outputs.
module tb_grf_writeback;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD, PC;

    logic [31:0] rd1_0, rd2_0, pc_0, data_0, cnt_0;
    logic [4:0]  addr_0;
    logic        val_0;
    logic [31:0] rd1_1, rd2_1, pc_1, data_1, cnt_1;
    logic [4:0]  addr_1;
    logic        val_1;
    logic [31:0] rd1_2, rd2_2, pc_2, data_2;
    logic [3:0]  cnt_2;
    logic [4:0]  addr_2;
    logic        val_2;

    rec_t        sb[$];
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    grf_writeback #(.BYPASS(0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_0), .RD2(rd2_0), .wb_valid(val_0), .wb_pc(pc_0), .wb_addr(addr_0),
        .wb_data(data_0), .wr_count(cnt_0));

    grf_writeback #(.BYPASS(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_1), .RD2(rd2_1), .wb_valid(val_1), .wb_pc(pc_1), .wb_addr(addr_1),
        .wb_data(data_1), .wr_count(cnt_1));

    grf_writeback #(.BYPASS(0), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .PC(PC),
        .RD1(rd1_2), .RD2(rd2_2), .wb_valid(val_2), .wb_pc(pc_2), .wb_addr(addr_2),
        .wb_data(data_2), .wr_count(cnt_2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Applies inputs mid-cycle; a committing write enqueues its expected trace record.
    task automatic set_in(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        WE = we; A3 = a3; WD = wd; PC = pc; A1 = a1; A2 = a2;
        if (we && a3 != 5'd0) begin
            exp_cnt = exp_cnt + 1;
            sb.push_back('{pc: pc, addr: a3, data: wd, cnt: exp_cnt});
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every wb_valid must match the oldest outstanding commit.
    always @(posedge clk) begin
        rec_t r;
        #2;
        if (val_0) begin
            $display("@%08h: $%2d <= %08h", pc_0, addr_0, data_0);
            if (sb.size() == 0) begin
                check("unexpected_wb_valid", 32'(val_0), 32'd0);
            end else begin
                r = sb.pop_front();
                check("trace_record", {27'd0, (pc_0 == r.pc), (addr_0 == r.addr),
                      (data_0 == r.data), (cnt_0 == r.cnt), 1'b1}, 32'h1f);
                if (pc_0 != r.pc || addr_0 != r.addr || data_0 != r.data || cnt_0 != r.cnt)
                    $display("FAIL trace_detail: got pc=%h a=%0d d=%h n=%0d, expected pc=%h a=%0d d=%h n=%0d",
                             pc_0, addr_0, data_0, cnt_0, r.pc, r.addr, r.data, r.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_cnt = 0;
        reset = 1'b1; WE = 1'b0; A1 = 5'd5; A2 = 5'd31; A3 = 5'd0; WD = '0; PC = '0;
        #2;
        check("reset_rd1", rd1_0, 32'd0);
        check("reset_valid", 32'(val_0), 32'd0);
        check("reset_count", cnt_0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First commit to $5.
        set_in(1'b1, 5'd5, 32'h12345678, 32'h00003000, 5'd5, 5'd0);
        edge_then_settle();
        check("t1_rd1", rd1_0, 32'h12345678);
        check("t1_rd2_zero", rd2_0, 32'd0);
        check("t1_valid", 32'(val_0), 32'd1);
        check("t1_addr", 32'(addr_0), 32'd5);
        check("t1_pc", pc_0, 32'h00003000);
        check("t1_count", cnt_0, 32'd1);

        // Write to $0 is dropped.
        set_in(1'b1, 5'd0, 32'hFFFFFFFF, 32'h00003004, 5'd0, 5'd0);
        edge_then_settle();
        check("t2_rd1_zero", rd1_0, 32'd0);
        check("t2_valid", 32'(val_0), 32'd0);
        check("t2_count", cnt_0, 32'd1);
        check("t2_addr_hold", 32'(addr_0), 32'd5);

        // Stored read vs write-through on a pending write to $7.
        set_in(1'b1, 5'd7, 32'h11, 32'h00003008, 5'd7, 5'd7);
        edge_then_settle();
        set_in(1'b1, 5'd7, 32'h22, 32'h0000300c, 5'd7, 5'd7);
        #1;
        check("byp0_rd1_pre", rd1_0, 32'h11);
        check("byp0_rd2_pre", rd2_0, 32'h11);
        check("byp1_rd1_pre", rd1_1, 32'h22);
        check("byp1_rd2_pre", rd2_1, 32'h22);
        edge_then_settle();
        check("byp0_rd1_post", rd1_0, 32'h22);
        check("byp1_rd2_post", rd2_1, 32'h22);

        // $0 reads 0 in the write-through instance even with a pending $0 write.
        set_in(1'b1, 5'd0, 32'h33, 32'h00003010, 5'd0, 5'd7);
        #1;
        check("byp1_zero_reg", rd1_1, 32'd0);
        check("byp1_rd2_stored", rd2_1, 32'h22);

        // Back-to-back writes to $1..$31.
        for (int n = 1; n <= 31; n++) begin
            set_in(1'b1, 5'(n), 32'hA0 + 32'(n), 32'h00004000 + 32'(4 * n), 5'd0, 5'd0);
            edge_then_settle();
            if (n > 1) check("b2b_valid", 32'(val_0), 32'd1);
        end
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        edge_then_settle();
        check("b2b_valid_low", 32'(val_0), 32'd0);
        check("b2b_count", cnt_0, 32'd34);
        for (int n = 1; n <= 31; n++) begin
            A1 = 5'(n);
            A2 = 5'(32 - n);
            #1;
            check("readback_rd1", rd1_0, 32'hA0 + 32'(n));
            check("readback_rd2", rd2_0, 32'hA0 + 32'(32 - n));
        end

        // Reset between edges during a pending write to $9.
        @(negedge clk);
        WE = 1'b1; A3 = 5'd9; WD = 32'hDEADBEEF; PC = 32'h00005000; A1 = 5'd9; A2 = 5'd31;
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        check("rst_rd1_reg9", rd1_0, 32'd0);
        check("rst_rd2_reg31", rd2_0, 32'd0);
        check("rst_byp1_rd1", rd1_1, 32'd0);
        check("rst_valid", 32'(val_0), 32'd0);
        check("rst_pc", pc_0, 32'd0);
        check("rst_addr", 32'(addr_0), 32'd0);
        check("rst_data", data_0, 32'd0);
        check("rst_count", cnt_0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        WE = 1'b0;
        #1;
        check("post_rst_reg9", rd1_0, 32'd0);
        set_in(1'b1, 5'd9, 32'h99, 32'h00006000, 5'd9, 5'd0);
        edge_then_settle();
        check("post_rst_count", cnt_0, 32'd1);
        check("post_rst_count4", 32'(cnt_2), 32'd1);
        check("post_rst_reg9_new", rd1_0, 32'h99);

        // 16 more commits: 17 since reset, so the 4-bit counter wraps to 1.
        for (int n = 0; n < 16; n++) begin
            set_in(1'b1, 5'(n + 10), 32'hC000 + 32'(n), 32'h00007000 + 32'(4 * n), 5'd0, 5'd0);
            edge_then_settle();
        end
        check("wrap_count4", 32'(cnt_2), 32'd1);
        check("wrap_count32", cnt_0, 32'd17);

        set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
